// File: rtl/vga_text_overlay.sv
// Text-overlay pixel generator: N fields of scaled glyphs, 2-cycle pipeline
// against a font ROM addressed by rom_addr, with a frame-synced blinking cursor.
module vga_text_overlay #(
    parameter int N_FIELDS        = 3,
    parameter int CHARS_PER_FIELD = 8,
    parameter int SCALE_LOG2      = 1,
    parameter logic [N_FIELDS*6-1:0] FIELD_COL = {N_FIELDS{6'd4}},
    parameter logic [N_FIELDS*5-1:0] FIELD_ROW = {N_FIELDS{5'd2}},
    parameter int BLINK_FRAMES    = 30,
    localparam int NFW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1,
    localparam int JW  = (CHARS_PER_FIELD > 1) ? $clog2(CHARS_PER_FIELD) : 1
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic [9:0]                            pix_x,
    input  logic [9:0]                            pix_y,
    input  logic                                  video_on,
    input  logic [N_FIELDS-1:0]                   field_en,
    input  logic [N_FIELDS*CHARS_PER_FIELD*7-1:0] field_chars,
    input  logic [N_FIELDS*3-1:0]                 field_rgb,
    input  logic                                  cursor_en,
    input  logic [NFW-1:0]                        cursor_field,
    input  logic [JW-1:0]                         cursor_pos,
    output logic [10:0]                           rom_addr,
    input  logic [7:0]                            font_word,
    output logic [2:0]                            graph_rgb,
    output logic                                  text_on
);

    localparam int CPF = CHARS_PER_FIELD;
    localparam int S   = SCALE_LOG2;
    localparam int CW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        BL_OFF,
        BL_INV,
        BL_NORM
    } blink_t;

    logic [9:0]          w_cx;
    logic [9:0]          w_cy;
    logic [3:0]          w_grow;
    logic [2:0]          w_gcol;
    logic [N_FIELDS-1:0] w_fhit;
    logic [JW-1:0]       w_fj [N_FIELDS];

    assign w_cx   = pix_x >> (3 + S);
    assign w_cy   = pix_y >> (4 + S);
    assign w_grow = 4'(pix_y >> S);
    assign w_gcol = 3'(pix_x >> S);

    for (genvar g = 0; g < N_FIELDS; g++) begin : g_fld
        logic [5:0]  w_col;
        logic [4:0]  w_row;
        logic [10:0] w_rel;
        assign w_col     = FIELD_COL[g*6 +: 6];
        assign w_row     = FIELD_ROW[g*5 +: 5];
        assign w_rel     = {1'b0, w_cx} - {5'd0, w_col};
        assign w_fhit[g] = field_en[g] && (w_cy == {5'd0, w_row})
                        && (w_cx >= {4'd0, w_col}) && (w_rel < 11'(CPF));
        assign w_fj[g]   = w_rel[JW-1:0];
    end

    logic           w_hit;
    logic [NFW-1:0] w_sel;
    logic [JW-1:0]  w_j;
    logic [6:0]     w_char;
    logic [2:0]     w_rgb;
    logic           w_cur;

    // Descending scan so the lowest-numbered overlapping field wins.
    always_comb begin
        w_hit  = 1'b0;
        w_sel  = '0;
        w_j    = '0;
        w_char = 7'h20;
        w_rgb  = 3'd0;
        for (int i = N_FIELDS - 1; i >= 0; i--) begin
            if (w_fhit[i]) begin
                w_hit = 1'b1;
                w_sel = NFW'(i);
                w_j   = w_fj[i];
                w_rgb = field_rgb[i*3 +: 3];
                for (int j = 0; j < CPF; j++) begin
                    if (w_fj[i] == JW'(j))
                        w_char = field_chars[(i*CPF+j)*7 +: 7];
                end
            end
        end
    end

    assign w_cur = cursor_en && w_hit
                && (cursor_field == w_sel) && (cursor_pos == w_j);

    logic [10:0] r_rom_addr;
    logic        r_hit;
    logic [2:0]  r_gcol;
    logic [2:0]  r_rgb;
    logic        r_cur;
    logic        r_von;
    logic [2:0]  r_graph;
    logic        r_text;
    logic        r_zero_d;
    blink_t      r_state;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rom_addr <= '0;
            r_hit      <= 1'b0;
            r_gcol     <= '0;
            r_rgb      <= '0;
            r_cur      <= 1'b0;
            r_von      <= 1'b0;
        end else begin
            r_rom_addr <= {w_char, w_grow};
            r_hit      <= w_hit;
            r_gcol     <= w_gcol;
            r_rgb      <= w_rgb;
            r_cur      <= w_cur;
            r_von      <= video_on;
        end
    end

    logic       w_bit;
    logic       w_phase;
    logic [2:0] w_graph_nx;

    assign w_bit   = font_word[3'd7 - r_gcol];
    assign w_phase = (r_state == BL_INV);

    always_comb begin
        w_graph_nx = 3'd0;
        if (r_von && r_hit) begin
            if (r_cur && w_phase)
                w_graph_nx = w_bit ? 3'd0 : r_rgb;
            else
                w_graph_nx = w_bit ? r_rgb : 3'd0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_graph <= '0;
            r_text  <= 1'b0;
        end else begin
            r_graph <= w_graph_nx;
            r_text  <= r_von && r_hit;
        end
    end

    logic   w_zero;
    logic   w_tick;
    blink_t w_state_nx;
    logic [CW-1:0] w_cnt_nx;

    assign w_zero = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign w_tick = w_zero && !r_zero_d;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            BL_OFF: begin
                w_cnt_nx = '0;
                if (cursor_en)
                    w_state_nx = BL_INV;
            end
            BL_INV, BL_NORM: begin
                if (!cursor_en) begin
                    w_state_nx = BL_OFF;
                    w_cnt_nx   = '0;
                end else if (w_tick) begin
                    if (r_cnt == CW'(BLINK_FRAMES - 1)) begin
                        w_cnt_nx   = '0;
                        w_state_nx = (r_state == BL_INV) ? BL_NORM : BL_INV;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nx = BL_OFF;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= BL_OFF;
            r_cnt    <= '0;
            r_zero_d <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_zero_d <= w_zero;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign graph_rgb = r_graph;
    assign text_on   = r_text;

endmodule

// File: tb/tb_vga_text_overlay.sv
// Directed bench for vga_text_overlay: 3 fields x 6 chars, scale 2,
// font ROM modelled as a lookup on the registered rom_addr.
module tb_vga_text_overlay;

    localparam int NF  = 3;
    localparam int CPF = 6;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              video_on;
    logic [NF-1:0]     field_en;
    logic [NF*CPF*7-1:0] field_chars;
    logic [NF*3-1:0]   field_rgb;
    logic              cursor_en;
    logic [1:0]        cursor_field;
    logic [2:0]        cursor_pos;
    logic [10:0]       rom_addr;
    logic [7:0]        font_word;
    logic [2:0]        graph_rgb;
    logic              text_on;

    int n_tot = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    vga_text_overlay #(
        .N_FIELDS(NF),
        .CHARS_PER_FIELD(CPF),
        .SCALE_LOG2(1),
        .FIELD_COL({6'd7, 6'd4, 6'd4}),
        .FIELD_ROW({5'd2, 5'd5, 5'd2}),
        .BLINK_FRAMES(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .video_on(video_on),
        .field_en(field_en),
        .field_chars(field_chars),
        .field_rgb(field_rgb),
        .cursor_en(cursor_en),
        .cursor_field(cursor_field),
        .cursor_pos(cursor_pos),
        .rom_addr(rom_addr),
        .font_word(font_word),
        .graph_rgb(graph_rgb),
        .text_on(text_on)
    );

    // '#' solid block, 'A' left half, 'H' real bitmap, everything else blank
    function automatic logic [7:0] font_fn(input logic [10:0] a);
        logic [6:0] c;
        logic [3:0] r;
        c = a[10:4];
        r = a[3:0];
        font_fn = 8'h00;
        if (c == 7'h23)
            font_fn = 8'hFF;
        else if (c == 7'h41)
            font_fn = 8'hF0;
        else if (c == 7'h48) begin
            if (r == 4'd6)
                font_fn = 8'h7E;
            else if ((r >= 4'd2 && r <= 4'd5) || (r >= 4'd7 && r <= 4'd10))
                font_fn = 8'h66;
        end
    endfunction

    assign font_word = font_fn(rom_addr);

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic put(input int x, input int y, input logic v);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame();
        put(0, 0, 1'b1);
        tick(1);
        put(112, 160, 1'b1);
        tick(2);
    endtask

    logic [2:0] blink_exp [6];

    initial begin
        RESET        = 1'b1;
        put(80, 64, 1'b1);
        field_en     = 3'b111;
        cursor_en    = 1'b0;
        cursor_field = 2'd1;
        cursor_pos   = 3'd3;
        for (int i = 0; i < NF; i++)
            for (int j = 0; j < CPF; j++)
                field_chars[(i*CPF+j)*7 +: 7] = (i == 2) ? 7'h41 : 7'h23;
        field_chars[6:0] = 7'h48;
        field_rgb = {3'b001, 3'b100, 3'b010};
        blink_exp[0] = 3'b000;
        blink_exp[1] = 3'b000;
        blink_exp[2] = 3'b100;
        blink_exp[3] = 3'b100;
        blink_exp[4] = 3'b000;
        blink_exp[5] = 3'b000;

        tick(3);
        chk("rst_rgb", 16'(graph_rgb), 16'h0);
        chk("rst_txt", 16'(text_on), 16'h0);
        chk("rst_addr", 16'(rom_addr), 16'h0);
        RESET = 1'b0;
        tick(1);
        chk("rel1_txt", 16'(text_on), 16'h0);
        chk("rel1_addr", 16'(rom_addr), 16'h230);
        tick(1);
        chk("rel2_rgb", 16'(graph_rgb), 16'h2);
        chk("rel2_txt", 16'(text_on), 16'h1);
        #2 RESET = 1'b1;
        #1;
        chk("async_rgb", 16'(graph_rgb), 16'h0);
        chk("async_txt", 16'(text_on), 16'h0);
        chk("async_addr", 16'(rom_addr), 16'h0);
        tick(1);
        RESET = 1'b0;
        tick(2);
        chk("rerel_rgb", 16'(graph_rgb), 16'h2);

        put(64, 76, 1'b1);
        tick(2);
        chk("h_c0r6", 16'(graph_rgb), 16'h0);
        chk("h_txt", 16'(text_on), 16'h1);
        put(66, 76, 1'b1);
        tick(1);
        chk("h_lat1", 16'(graph_rgb), 16'h0);
        chk("h_addr", 16'(rom_addr), 16'h486);
        tick(1);
        chk("h_c1r6", 16'(graph_rgb), 16'h2);
        put(66, 68, 1'b1);
        tick(2);
        chk("h_c1r2", 16'(graph_rgb), 16'h2);
        put(70, 68, 1'b1);
        tick(2);
        chk("h_c3r2", 16'(graph_rgb), 16'h0);
        put(66, 64, 1'b1);
        tick(2);
        chk("h_c1r0", 16'(graph_rgb), 16'h0);

        put(160, 160, 1'b1);
        tick(2);
        chk("b_f1_end", 16'(text_on), 16'h0);
        put(159, 160, 1'b1);
        tick(2);
        chk("b_f1_last", 16'(graph_rgb), 16'h4);
        put(48, 160, 1'b1);
        tick(2);
        chk("b_f1_left", 16'(text_on), 16'h0);
        put(112, 64, 1'b1);
        tick(2);
        chk("ov_lo", 16'(graph_rgb), 16'h2);
        put(160, 64, 1'b1);
        tick(2);
        chk("f2_rgb", 16'(graph_rgb), 16'h1);
        chk("f2_addr", 16'(rom_addr), 16'h410);
        field_en = 3'b110;
        put(112, 64, 1'b1);
        tick(2);
        chk("en0_ov", 16'(graph_rgb), 16'h1);
        put(80, 64, 1'b1);
        tick(2);
        chk("en0_txt", 16'(text_on), 16'h0);
        field_en = 3'b111;

        put(112, 64, 1'b1);
        tick(2);
        chk("von_on", 16'(graph_rgb), 16'h2);
        put(112, 64, 1'b0);
        tick(1);
        chk("von_lat1", 16'(text_on), 16'h1);
        tick(1);
        chk("von_txt", 16'(text_on), 16'h0);
        chk("von_rgb", 16'(graph_rgb), 16'h0);

        put(112, 160, 1'b1);
        tick(2);
        chk("cur_pre", 16'(graph_rgb), 16'h4);
        cursor_en = 1'b1;
        tick(2);
        chk("cur_f0", 16'(graph_rgb), 16'(blink_exp[0]));
        for (int k = 1; k < 6; k++) begin
            frame();
            chk($sformatf("cur_f%0d", k), 16'(graph_rgb), 16'(blink_exp[k]));
        end
        cursor_en = 1'b0;
        tick(2);
        chk("cur_off", 16'(graph_rgb), 16'h4);

        cursor_en = 1'b1;
        tick(2);
        chk("hold_pre", 16'(graph_rgb), 16'h0);
        put(0, 0, 1'b1);
        tick(4);
        put(112, 160, 1'b1);
        tick(2);
        chk("hold_a", 16'(graph_rgb), 16'h0);
        frame();
        chk("hold_b", 16'(graph_rgb), 16'h4);
        cursor_en = 1'b0;
        tick(1);

        cursor_field = 2'd3;
        cursor_pos   = 3'd3;
        cursor_en    = 1'b1;
        tick(2);
        chk("inv_f0", 16'(graph_rgb), 16'h4);
        for (int k = 1; k < 8; k++) begin
            cursor_field = k[0] ? 2'd1 : 2'd3;
            cursor_pos   = k[0] ? 3'd6 : 3'd3;
            frame();
            chk($sformatf("inv_f%0d", k), 16'(graph_rgb), 16'h4);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
